// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
//   Definitions shared by the APB master and the APB completers:
//   - transfer-phase state encoding (IDLE / SETUP / ACCESS)
//   - default bus widths
//   - byte-to-word address alignment (low address bits ignored for indexing)
// ---------------------------------------------------------------------------
package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH = 8;
    localparam int unsigned APB_DATA_WIDTH = 32;

    // Word registers: paddr[1:0] select a byte within the word
    localparam int unsigned APB_ALIGN = 2;

    typedef logic [1:0] apb_state_t;

    localparam apb_state_t APB_IDLE   = 2'd0;
    localparam apb_state_t APB_SETUP  = 2'd1;
    localparam apb_state_t APB_ACCESS = 2'd2;

endpackage

// File: rtl/apb_slave_regbank.sv
// ---------------------------------------------------------------------------
// apb_slave_regbank
//   Register storage for apb_slave. Entries 0..NUM_REGS-2 are read/write;
//   index NUM_REGS-1 reads back the live status_in word and has no storage.
//
// Ports:
//   pclk       clock, rising edge
//   rst        synchronous active-high reset, clears all registers
//   we         write enable (already qualified by the caller)
//   widx       register index to write
//   wdata      write data
//   ridx       register index to read (combinational read)
//   status_in  value returned for index NUM_REGS-1
//   rdata      combinational read data
//   ctrl_out   live contents of register 0
// ---------------------------------------------------------------------------
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      ridx,
    input  logic [DATA_WIDTH-1:0] status_in,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] ctrl_out
);

    // Only the read/write entries are stored
    logic [DATA_WIDTH-1:0] regs [NUM_REGS-1];

    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
                if (we && (widx == IDX_W'(i))) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
            if (ridx == IDX_W'(i)) begin
                rdata = regs[i];
            end
        end
        if (ridx == IDX_W'(NUM_REGS - 1)) begin
            rdata = status_in;
        end
    end

    assign ctrl_out = regs[0];

endmodule

// File: rtl/apb_slave.sv
// ---------------------------------------------------------------------------
// apb_slave
//   APB completer in front of a small register bank. NUM_REGS word registers;
//   the last one is a read-only status word taken from status_in. Every
//   committed write is echoed to the IP as a one-cycle strobe with index/data.
//
//   Optional feature macro: APB3_EN
//     defined   -> pready/pslverr ports, WAIT_CYCLES wait states per access
//     undefined -> no pready/pslverr, zero-wait access, errors silently dropped
//
// Ports:
//   pclk       clock, rising edge
//   rst        synchronous active-high reset
//   psel       APB select
//   penable    APB enable (access phase)
//   pwrite     1 = write, 0 = read
//   paddr      byte address
//   pwdata     write data
//   prdata     registered read data, valid during ACCESS
//   status_in  value returned for register NUM_REGS-1
//   ctrl_out   live contents of register 0
//   wr_strobe  one-cycle pulse after each committed write
//   wr_index   register index of that write
//   wr_data    data of that write
//   pready     (APB3_EN) transfer completion
//   pslverr    (APB3_EN) error response, valid with pready
// ---------------------------------------------------------------------------
module apb_slave
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                         pclk,
    input  logic                         rst,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_WIDTH-1:0]        paddr,
    input  logic [DATA_WIDTH-1:0]        pwdata,
    output logic [DATA_WIDTH-1:0]        prdata,
    input  logic [DATA_WIDTH-1:0]        status_in,
    output logic [DATA_WIDTH-1:0]        ctrl_out,
    output logic                         wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0]  wr_index,
    output logic [DATA_WIDTH-1:0]        wr_data
`ifdef APB3_EN
    ,
    output logic                         pready,
    output logic                         pslverr
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    // Without APB3_EN the wait limit is pinned to 0, so the counter always
    // matches and every ACCESS cycle is ready, i.e. zero-wait operation.
`ifdef APB3_EN
    localparam int unsigned WAIT_LIM = WAIT_CYCLES;
`else
    localparam int unsigned WAIT_LIM = WAIT_CYCLES * 0;
`endif
    localparam logic [3:0] WAIT_MAX = 4'(WAIT_LIM);

    apb_state_t            state;
    logic [3:0]            wait_cnt;
    logic [IDX_W-1:0]      idx;
    logic                  addr_valid;
    logic                  ready_int;
    logic                  done;
    logic                  commit;
    logic [DATA_WIDTH-1:0] rd_data;

    // Word index; valid only if word-aligned and no address bits above it
    assign idx        = paddr[APB_ALIGN +: IDX_W];
    assign addr_valid = (paddr[APB_ALIGN-1:0] == '0) &&
                        ((paddr >> (APB_ALIGN + IDX_W)) == '0);

    assign ready_int = (state == APB_ACCESS) && (wait_cnt == WAIT_MAX);
    assign done      = ready_int && psel && penable;
    assign commit    = done && pwrite && addr_valid && (idx != LAST_IDX);

    always_ff @(posedge pclk) begin
        if (rst) begin
            state    <= APB_IDLE;
            prdata   <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                APB_IDLE: begin
                    prdata   <= '0;
                    wait_cnt <= '0;
                    // psel & penable without a setup phase is ignored
                    if (psel && !penable) begin
                        state <= APB_SETUP;
                    end
                end
                APB_SETUP: begin
                    state    <= APB_ACCESS;
                    wait_cnt <= '0;
                    prdata   <= (!pwrite && addr_valid) ? rd_data : '0;
                end
                APB_ACCESS: begin
                    if (!psel || done) begin
                        // abort or completion; abort never commits
                        state  <= APB_IDLE;
                        prdata <= '0;
                    end else if (wait_cnt != WAIT_MAX) begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: begin
                    state  <= APB_IDLE;
                    prdata <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            wr_data   <= '0;
        end else begin
            wr_strobe <= commit;
            if (commit) begin
                wr_index <= idx;
                wr_data  <= pwdata;
            end
        end
    end

`ifdef APB3_EN
    assign pready  = ready_int;
    assign pslverr = ready_int && (!addr_valid || (pwrite && (idx == LAST_IDX)));
`endif

    apb_slave_regbank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_regbank (
        .pclk      (pclk),
        .rst       (rst),
        .we        (commit),
        .widx      (idx),
        .wdata     (pwdata),
        .ridx      (idx),
        .status_in (status_in),
        .rdata     (rd_data),
        .ctrl_out  (ctrl_out)
    );

endmodule

// File: tb/tb_apb_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_slave
//   Self-checking bench for apb_slave. Builds with or without APB3_EN.
//   Expected values come from a word-array model of the register map.
// ---------------------------------------------------------------------------
module tb_apb_slave;

    localparam int unsigned ADDR_WIDTH = 8;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned NUM_REGS   = 8;
`ifdef APB3_EN
    localparam int unsigned WAIT_CYCLES = 3;
`else
    localparam int unsigned WAIT_CYCLES = 1;
`endif

    logic                  pclk;
    logic                  rst;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic [DATA_WIDTH-1:0] status_in;
    logic [DATA_WIDTH-1:0] ctrl_out;
    logic                  wr_strobe;
    logic [2:0]            wr_index;
    logic [DATA_WIDTH-1:0] wr_data;
`ifdef APB3_EN
    logic                  pready;
    logic                  pslverr;
`endif

    apb_slave #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_REGS    (NUM_REGS),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .status_in (status_in),
        .ctrl_out  (ctrl_out),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .wr_data   (wr_data)
`ifdef APB3_EN
        ,
        .pready    (pready),
        .pslverr   (pslverr)
`endif
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    // Reference register map: index NUM_REGS-1 is the status word
    logic [31:0] ref_regs [NUM_REGS];
    logic [31:0] ref_status;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [7:0] a);
        return (int'(a) % 4 == 0) && (int'(a) < int'(NUM_REGS) * 4);
    endfunction

    function automatic int unsigned addr_reg(input logic [7:0] a);
        return (int'(a) / 4) % NUM_REGS;
    endfunction

    task automatic set_status(input logic [31:0] v);
        status_in  = v;
        ref_status = v;
    endtask

    // One complete transfer; checks strobe, prdata, ctrl_out (and pready/pslverr)
    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data);
        logic [31:0] exp_rd;
        bit          ok;
        bit          commit_exp;
        int unsigned r;
        int unsigned waits;
        logic        got_ready;

        ok         = addr_ok(addr);
        r          = addr_reg(addr);
        exp_rd     = (!wr && ok) ? ((r == NUM_REGS - 1) ? ref_status : ref_regs[r]) : 32'h0;
        commit_exp = wr && ok && (r < NUM_REGS - 1);

        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(negedge pclk);
        check("strobe_single", 32'(wr_strobe), 32'h0);
`ifdef APB3_EN
        check("pready_setup", 32'(pready), 32'h0);
`endif
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk);                 // slave now in ACCESS
        waits     = 0;
        got_ready = 1'b0;
        for (int k = 0; k < 40 && !got_ready; k++) begin
            @(negedge pclk);
`ifdef APB3_EN
            got_ready = pready;
`else
            got_ready = 1'b1;
`endif
            if (!got_ready) begin
                waits++;
                check("wait_no_strobe", 32'(wr_strobe), 32'h0);
                check("wait_ctrl", ctrl_out, ref_regs[0]);
                @(posedge pclk);
            end
        end
`ifdef APB3_EN
        check("ready_timeout", 32'(got_ready), 32'h1);
        check("wait_states", 32'(waits), 32'(WAIT_CYCLES));
        check("pslverr", 32'(pslverr), 32'(!ok || (wr && r == NUM_REGS - 1)));
`endif
        check("access_prdata", prdata, exp_rd);
        check("ctrl_before_commit", ctrl_out, ref_regs[0]);
        @(posedge pclk); #1;             // completion edge passed
        psel = 1'b0; penable = 1'b0;
        if (commit_exp) ref_regs[r] = data;
        @(negedge pclk);
        check("wr_strobe", 32'(wr_strobe), 32'(commit_exp));
        if (commit_exp) begin
            check("wr_index", 32'(wr_index), 32'(r));
            check("wr_data", wr_data, data);
        end
        check("prdata_after", prdata, 32'h0);
        check("ctrl_out", ctrl_out, ref_regs[0]);
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        logic        w;

        for (int i = 0; i < int'(NUM_REGS); i++) ref_regs[i] = 32'h0;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        set_status(32'h0);

        // Power-on reset
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check("rst_prdata", prdata, 32'h0);
        check("rst_strobe", 32'(wr_strobe), 32'h0);
        check("rst_index", 32'(wr_index), 32'h0);
        check("rst_wdata", wr_data, 32'h0);
        check("rst_ctrl", ctrl_out, 32'h0);
        @(posedge pclk); #1;
        rst = 1'b0;

        // Reset asserted while a write to 0x04 sits in ACCESS
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'hCAFEF00D;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        rst = 1'b1;
        repeat (2) begin
            @(negedge pclk);
            check("midrst_strobe", 32'(wr_strobe), 32'h0);
            check("midrst_prdata", prdata, 32'h0);
        end
        @(posedge pclk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("midrst_after_strobe", 32'(wr_strobe), 32'h0);
        apb_xfer(1'b0, 8'h04, 32'h0);    // register 1 must still be 0

        // Write / read back
        apb_xfer(1'b1, 8'h08, 32'hDEADBEEF);
        apb_xfer(1'b0, 8'h08, 32'h0);

        // Status word and ctrl_out
        set_status(32'h1234);
        apb_xfer(1'b0, 8'h1C, 32'h0);
        apb_xfer(1'b1, 8'h1C, 32'h00000055);
        apb_xfer(1'b0, 8'h1C, 32'h0);
        apb_xfer(1'b1, 8'h00, 32'h000000A5);

        // Invalid addresses
        apb_xfer(1'b0, 8'h22, 32'h0);
        apb_xfer(1'b0, 8'h40, 32'h0);
        apb_xfer(1'b1, 8'h40, 32'h11111111);
        apb_xfer(1'b0, 8'h00, 32'h0);

        // psel & penable without a setup phase is ignored
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h77777777;
        repeat (3) begin
            @(negedge pclk);
            check("nosetup_strobe", 32'(wr_strobe), 32'h0);
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        apb_xfer(1'b0, 8'h0C, 32'h0);

        // Master drops psel once the slave is in ACCESS
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h99999999;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            check("abort_strobe", 32'(wr_strobe), 32'h0);
        end
        apb_xfer(1'b0, 8'h10, 32'h0);
        apb_xfer(1'b1, 8'h10, 32'h0BADF00D);
        apb_xfer(1'b0, 8'h10, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) set_status($urandom);
            if ($urandom_range(0, 4) == 0) a = 8'($urandom);
            else                           a = 8'($urandom_range(0, NUM_REGS - 1) * 4);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            apb_xfer(w, a, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
